// File: rtl/ddr_clock_pkg.sv
// Shared definitions for the DDR clock pair generator.
// Optional build macro: DDR_CLOCK_DEADBAND_EN (break-before-make deadband,
// which also raises the minimum effective half-period to 2 cycles).
package ddr_clock_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int DEF_DIV_WIDTH    = 8;
   localparam int DEF_START_CYCLES = 16;
   localparam int DEF_CNT_WIDTH    = 6;

   // Effective half-period length in system clock cycles for a Divide value.
   function automatic int unsigned eff_divide(input int unsigned divide);
`ifdef DDR_CLOCK_DEADBAND_EN
      // One cycle of every half-period is the deadband, so at least one
      // more cycle is needed to actually drive a phase high.
      return (divide < 32'd2) ? 32'd2 : divide;
`else
      return (divide < 32'd1) ? 32'd1 : divide;
`endif
   endfunction

endpackage

// File: rtl/half_period_counter.sv
// Half-period down counter: loads a reload value, counts down while the
// clock pair is toggling, and flags the last cycle of each half-period.
module half_period_counter
   import ddr_clock_pkg::*;
#(
   parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Load,
   input  logic [DIV_WIDTH-1:0] LoadValue,
   input  logic                 Run,
   output logic                 Terminal
);

   logic [DIV_WIDTH-1:0] count;

   // Load has priority; otherwise count down towards zero while running.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         count <= '0;
      end else if (Load) begin
         count <= LoadValue;
      end else if (Run && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // Zero while running marks the final cycle of the current half-period.
   assign Terminal = Run && (count == '0);

endmodule

// File: rtl/ddr_clock_pair_gen.sv
// Complementary DDR clock pair generator with programmable half-period,
// warm-up phase before Ready, and glitch-free start/stop.
// Optional build macro: DDR_CLOCK_DEADBAND_EN (both outputs low for the first
// cycle of every half-period).
module ddr_clock_pair_gen
   import ddr_clock_pkg::*;
#(
   parameter int DIV_WIDTH    = DEF_DIV_WIDTH,
   parameter int START_CYCLES = DEF_START_CYCLES,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Enable,
   input  logic [DIV_WIDTH-1:0] Divide,
   output logic                 ClockP,
   output logic                 ClockN,
   output logic                 Running,
   output logic                 Ready
);

`ifdef DDR_CLOCK_DEADBAND_EN
   localparam logic DEADBAND = 1'b1;
`else
   localparam logic DEADBAND = 1'b0;
`endif

   localparam logic [CNT_WIDTH-1:0] START_CNT = CNT_WIDTH'(START_CYCLES);

   state_t               state;
   state_t               state_next;
   state_t               mode;
   logic                 phase;
   logic                 phase_next;
   logic [CNT_WIDTH-1:0] toggles;
   logic [CNT_WIDTH-1:0] toggles_next;
   logic                 clock_p_next;
   logic                 clock_n_next;
   logic                 ready_next;
   logic                 load;
   logic                 terminal;
   logic [DIV_WIDTH-1:0] load_value;

   // Divide is only consumed when the counter is (re)loaded, so a change
   // mid-phase takes effect from the next half-period.
   assign load_value = DIV_WIDTH'(eff_divide(32'(Divide)) - 32'd1);

   assign Running = (state != IDLE);

   half_period_counter #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_half_period_counter (
      .Clock     (Clock),
      .Reset     (Reset),
      .Load      (load),
      .LoadValue (load_value),
      .Run       (Running),
      .Terminal  (terminal)
   );

   // Next-state, phase, toggle count and next output values.
   always_comb begin
      state_next   = state;
      mode         = state;
      phase_next   = phase;
      toggles_next = toggles;
      ready_next   = Ready;
      clock_p_next = ClockP;
      clock_n_next = ClockN;
      load         = 1'b0;

      case (state)
         IDLE: begin
            clock_p_next = 1'b0;
            clock_n_next = 1'b0;
            if (Enable) begin
               state_next   = START;
               phase_next   = 1'b1;
               toggles_next = '0;
               load         = 1'b1;
               clock_p_next = !DEADBAND;
            end
         end

         default: begin
            // The operating mode this cycle: a dropped Enable drains, a
            // re-raised Enable resumes whichever phase of operation the
            // Ready flag says we were in, without touching the clock phase.
            if (!Enable) begin
               mode = DRAIN;
            end else if (state == DRAIN) begin
               mode = Ready ? RUN : START;
            end else begin
               mode = state;
            end
            state_next   = mode;
            clock_p_next = phase;
            clock_n_next = !phase;

            if (terminal) begin
               if ((mode == DRAIN) && !phase) begin
                  // ClockP would rise here: stop instead, so the last high
                  // phase was always a full one.
                  state_next   = IDLE;
                  phase_next   = 1'b0;
                  toggles_next = '0;
                  ready_next   = 1'b0;
                  clock_p_next = 1'b0;
                  clock_n_next = 1'b0;
               end else begin
                  load         = 1'b1;
                  phase_next   = !phase;
                  toggles_next = (toggles >= START_CNT) ? START_CNT : toggles + 1'b1;
                  clock_p_next = !phase && !DEADBAND;
                  clock_n_next = phase && !DEADBAND;
                  if ((mode == START) && (toggles_next >= START_CNT)) begin
                     state_next = RUN;
                     ready_next = 1'b1;
                  end
               end
            end
         end
      endcase
   end

   // State and registered output update.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         phase   <= 1'b0;
         toggles <= '0;
         ClockP  <= 1'b0;
         ClockN  <= 1'b0;
         Ready   <= 1'b0;
      end else begin
         state   <= state_next;
         phase   <= phase_next;
         toggles <= toggles_next;
         ClockP  <= clock_p_next;
         ClockN  <= clock_n_next;
         Ready   <= ready_next;
      end
   end

endmodule
